wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, the number of cycles without ack after which an owned cycle is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_mN_cyc, i_mN_stb, i_mN_we  input  1 each  Wishbone master N requests (N=0 data port, N=1 fetch port).
REQ-005 i_mN_sel  input  4; i_mN_addr  input  30; i_mN_data  input  32  master N byte select, word address, write data.
REQ-006 o_mN_ack, o_mN_stall, o_mN_err  output  1 each  per-master ack, stall, abort indication.
REQ-007 o_mN_data  output  32  read data to master N.
REQ-008 o_s_cyc, o_s_stb, o_s_we  output  1; o_s_sel  output  4; o_s_addr  output  30; o_s_data  output  32  shared slave port.
REQ-009 i_s_ack, i_s_stall  input  1; i_s_data  input  32  slave responses.

Function
REQ-010 The FSM SHALL have states IDLE, OWN0, OWN1, ABORT; a register last (1 bit) SHALL record the most recently granted master.
REQ-011 In IDLE, next state SHALL be OWN0 if only i_m0_cyc, OWN1 if only i_m1_cyc, and OWN(not last) if both; grant latency SHALL be one cycle from cyc seen in IDLE.
REQ-012 In IDLE and ABORT, o_s_cyc, o_s_stb, o_s_we SHALL be 0 and o_s_sel, o_s_addr, o_s_data SHALL be 0; both masters see stall=1, ack=0.
REQ-013 In OWNn, o_s_cyc=i_mN_cyc, o_s_stb=i_mN_stb AND (cnt!=7), and we/sel/addr/data SHALL be muxed from master N combinationally.
REQ-014 In OWNn, o_mN_stall SHALL be i_s_stall OR (cnt==7), o_mN_ack SHALL be i_s_ack; the non-owning master SHALL see stall=1, ack=0, err=0.
REQ-015 o_m0_data and o_m1_data SHALL both equal i_s_data at all times.
REQ-016 cnt (3 bits, outstanding requests) SHALL +1 on o_s_stb AND NOT i_s_stall, -1 on i_s_ack, hold when both, never decrement below 0.
REQ-017 When cnt==7, new strobes SHALL be blocked (REQ-013/014) until an ack arrives; cnt SHALL never wrap.
REQ-018 OWNn SHALL exit to IDLE in the cycle after i_mN_cyc is sampled low; on exit cnt and watchdog clear and last<=n; at least one IDLE cycle separates grants.
REQ-019 Acks arriving in IDLE or ABORT SHALL be discarded (not forwarded, no counter change).
REQ-020 The watchdog (8+ bits, sized to TIMEOUT) SHALL count cycles in OWNn with cnt>0 and i_s_ack=0, and clear on any ack or cnt==0.
REQ-021 When the watchdog reaches TIMEOUT, o_mN_err SHALL pulse 1 for exactly one cycle, the FSM SHALL enter ABORT, and cnt SHALL clear.
REQ-022 ABORT SHALL hold until i_mN_cyc (of the aborted master) is sampled low, then go to IDLE with last<=n.
REQ-023 Master dropping cyc with cnt>0 SHALL be treated as a legal Wishbone abort: same as REQ-018, no error.

Reset
REQ-024 While reset=0: state=IDLE, last=1, cnt=0, watchdog=0; all o_s_* =0, o_mN_ack=0, o_mN_err=0, o_mN_stall=1.
REQ-025 Reset asserted mid-cycle SHALL drop o_s_cyc immediately (asynchronous) and discard any in-flight acks after release.

Verification
REQ-026 Both cyc rise together after reset -> OWN0 granted next cycle; m1 stall=1 until m0 drops cyc, then one IDLE cycle, then OWN1.
REQ-027 m0 issues 3 pipelined reads at 0x100..0x102, slave acks with data 0xA0,0xA1,0xA2 -> m0 gets 3 acks with that data, cnt returns 0, m1 sees no ack.
REQ-028 m1 issues 9 back-to-back strobes, slave stall=0 and never acks -> 7 accepted, o_m1_stall=1 from the 8th; one ack -> 8th accepted.
REQ-029 TIMEOUT=4, m0 strobe accepted, no ack -> o_m0_err pulses after 4 cycles, o_s_cyc=0, ABORT held until m0 drops cyc.
REQ-030 m0 and m1 request continuously -> grants alternate OWN0, OWN1, OWN0 on each cyc release.
REQ-031 Late ack arriving one cycle after owner drops cyc -> neither master sees ack, cnt stays 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone pipelined arbiter with per-grant outstanding-request
// tracking and a stuck-slave watchdog.
//   clk, reset        : clock, asynchronous active-low reset
//   i_m0_* / o_m0_*   : master 0 (data port) request / response
//   i_m1_* / o_m1_*   : master 1 (fetch port) request / response
//   o_s_* / i_s_*     : shared slave port
// The slave-side request and per-master ack/stall are combinational views of
// the owning master; err is a registered one-cycle pulse on watchdog abort.
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_sel,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_stall,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_stall,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [3:0]  o_s_sel,
    output logic [29:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic        i_s_ack,
    input  logic        i_s_stall,
    input  logic [31:0] i_s_data
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WD_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned WD_W   = (WD_RAW > 8) ? WD_RAW : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    state_t            state;
    logic              last;
    logic [CNT_W-1:0]  cnt;
    logic [WD_W-1:0]   wd;
    logic              m0_err_q;
    logic              m1_err_q;

    logic own_c;
    logic own_cyc_c;
    logic cnt_full_c;
    logic accept_c;
    logic dec_c;
    logic wd_run_c;
    logic timeout_c;

    // Qualifiers for the current owner
    assign own_c      = (state == OWN0) || (state == OWN1);
    assign own_cyc_c  = (state == OWN0) ? i_m0_cyc : ((state == OWN1) ? i_m1_cyc : 1'b0);
    assign cnt_full_c = (cnt == CNT_MAX);
    assign accept_c   = o_s_stb && !i_s_stall;
    assign dec_c      = own_c && i_s_ack && (cnt != '0);
    assign wd_run_c   = own_c && (cnt != '0) && !i_s_ack;
    // Fire on the cycle that would bring the watchdog to TIMEOUT
    assign timeout_c  = wd_run_c && (wd == WD_W'(TIMEOUT - 1));

    // Slave request mux and per-master ack/stall
    always_comb begin
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_sel    = '0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        case (state)
            OWN0: begin
                o_s_cyc    = i_m0_cyc;
                o_s_stb    = i_m0_stb && !cnt_full_c;
                o_s_we     = i_m0_we;
                o_s_sel    = i_m0_sel;
                o_s_addr   = i_m0_addr;
                o_s_data   = i_m0_data;
                o_m0_stall = i_s_stall || cnt_full_c;
                o_m0_ack   = i_s_ack;
            end
            OWN1: begin
                o_s_cyc    = i_m1_cyc;
                o_s_stb    = i_m1_stb && !cnt_full_c;
                o_s_we     = i_m1_we;
                o_s_sel    = i_m1_sel;
                o_s_addr   = i_m1_addr;
                o_s_data   = i_m1_data;
                o_m1_stall = i_s_stall || cnt_full_c;
                o_m1_ack   = i_s_ack;
            end
            default: ;
        endcase
    end

    assign o_m0_err  = m0_err_q;
    assign o_m1_err  = m1_err_q;
    assign o_m0_data = i_s_data;
    assign o_m1_data = i_s_data;

    // Arbitration FSM, outstanding counter and watchdog.
    // last is written at grant time, so ABORT knows which master to wait on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            cnt      <= '0;
            wd       <= '0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    wd  <= '0;
                    if (i_m0_cyc && (!i_m1_cyc || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state <= OWN1;
                        last  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                        wd    <= '0;
                    end else if (timeout_c) begin
                        state <= ABORT;
                        cnt   <= '0;
                        wd    <= '0;
                        if (state == OWN0) m0_err_q <= 1'b1;
                        else               m1_err_q <= 1'b1;
                    end else begin
                        if (accept_c && !dec_c)      cnt <= cnt + CNT_W'(1);
                        else if (dec_c && !accept_c) cnt <= cnt - CNT_W'(1);
                        wd <= wd_run_c ? (wd + WD_W'(1)) : '0;
                    end
                end
                ABORT: begin
                    cnt <= '0;
                    wd  <= '0;
                    if (!(last ? i_m1_cyc : i_m0_cyc)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Stimulus pushes expected ack/err events into a
// queue; a negedge monitor pops and compares every ack/err the main DUT shows.
// A second instance with TIMEOUT=4 shares all inputs for the watchdog test.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = '0;
    logic [29:0] m0_addr = '0;
    logic [31:0] m0_data = '0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = '0;
    logic [29:0] m1_addr = '0;
    logic [31:0] m1_data = '0;
    logic        s_ack = 0, s_stall = 0;
    logic [31:0] s_data = '0;

    logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
    logic [31:0] o_m0_data, o_m1_data, o_s_data;
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [3:0]  o_s_sel;
    logic [29:0] o_s_addr;

    logic        t_m0_ack, t_m0_stall, t_m0_err, t_m1_ack, t_m1_stall, t_m1_err;
    logic [31:0] t_m0_data, t_m1_data, t_s_data;
    logic        t_s_cyc, t_s_stb, t_s_we;
    logic [3:0]  t_s_sel;
    logic [29:0] t_s_addr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned port;
        int unsigned kind;   // 0 = ack, 1 = err
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
        .i_m0_addr(m0_addr), .i_m0_data(m0_data),
        .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
        .i_m1_addr(m1_addr), .i_m1_data(m1_data),
        .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data)
    );

    wb_arbiter #(.TIMEOUT(4)) dut_t (
        .clk(clk), .reset(reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
        .i_m0_addr(m0_addr), .i_m0_data(m0_data),
        .o_m0_ack(t_m0_ack), .o_m0_stall(t_m0_stall), .o_m0_err(t_m0_err), .o_m0_data(t_m0_data),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
        .i_m1_addr(m1_addr), .i_m1_data(m1_data),
        .o_m1_ack(t_m1_ack), .o_m1_stall(t_m1_stall), .o_m1_err(t_m1_err), .o_m1_data(t_m1_data),
        .o_s_cyc(t_s_cyc), .o_s_stb(t_s_stb), .o_s_we(t_s_we), .o_s_sel(t_s_sel),
        .o_s_addr(t_s_addr), .o_s_data(t_s_data),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned port, input int unsigned kind, input logic [31:0] d);
        ev_t e;
        e.port = port;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int unsigned port, input int unsigned kind, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual port=%0d kind=%0d data=%h required=none", port, kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.port != port || e.kind != kind || (kind == 0 && e.data !== d)) begin
                errors++;
                $display("FAIL event: actual port=%0d kind=%0d data=%h required port=%0d kind=%0d data=%h",
                         port, kind, d, e.port, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every ack/err on the main DUT must match the next expected event
    always @(negedge clk) begin
        if (reset) begin
            if (o_m0_ack) mon(0, 0, o_m0_data);
            if (o_m1_ack) mon(1, 0, o_m1_data);
            if (o_m0_err) mon(0, 1, 32'h0);
            if (o_m1_err) mon(1, 1, 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        smp();
        chk("rst_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("rst_s_stb", 32'(o_s_stb), 32'd0);
        chk("rst_m0_stall", 32'(o_m0_stall), 32'd1);
        chk("rst_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("rst_acks", {30'd0, o_m0_ack, o_m1_ack}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // Simultaneous request: m0 wins first
        m0_cyc = 1; m1_cyc = 1;
        smp();
        chk("idle_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("idle_m0_stall", 32'(o_m0_stall), 32'd1);
        step();
        m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 30'h100;
        smp();
        chk("own0_s_cyc", 32'(o_s_cyc), 32'd1);
        chk("own0_m0_stall", 32'(o_m0_stall), 32'd0);
        chk("own0_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("own0_addr0", 32'(o_s_addr), 32'h100);
        chk("own0_stb", 32'(o_s_stb), 32'd1);
        step();
        m0_addr = 30'h101;
        smp();
        chk("own0_addr1", 32'(o_s_addr), 32'h101);
        step();
        m0_addr = 30'h102;
        step();

        // Three pipelined read acks back to m0
        m0_stb = 0;
        for (int i = 0; i < 3; i++) begin
            s_ack = 1; s_data = 32'hA0 + 32'(i);
            push(0, 0, 32'hA0 + 32'(i));
            smp();
            chk("m1_sees_data", o_m1_data, 32'hA0 + 32'(i));
            step();
        end
        s_ack = 0;

        // m0 releases; one idle cycle; then m1 owns
        m0_cyc = 0;
        smp();
        chk("drop_s_cyc", 32'(o_s_cyc), 32'd0);
        step();
        smp();
        chk("gap_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("gap_s_cyc", 32'(o_s_cyc), 32'd0);
        step();
        smp();
        chk("own1_m1_stall", 32'(o_m1_stall), 32'd0);
        chk("own1_m0_stall", 32'(o_m0_stall), 32'd1);

        // m1 streams strobes with no acks: seven accepted, then blocked
        m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_addr = 30'h200; m1_data = 32'hDEADBEEF;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                smp();
                chk("own1_wdata", o_s_data, 32'hDEADBEEF);
                chk("own1_we", 32'(o_s_we), 32'd1);
                chk("own1_sel", 32'(o_s_sel), 32'h3);
            end
        end
        smp();
        chk("full_m1_stall", 32'(o_m1_stall), 32'd1);
        chk("full_s_stb", 32'(o_s_stb), 32'd0);
        step();
        s_ack = 1; s_data = 32'hB0;
        push(1, 0, 32'hB0);
        smp();
        chk("full_stall_during_ack", 32'(o_m1_stall), 32'd1);
        step();
        s_ack = 0;
        smp();
        chk("eighth_accept_stall", 32'(o_m1_stall), 32'd0);
        chk("eighth_accept_stb", 32'(o_s_stb), 32'd1);
        step();
        smp();
        chk("refull_m1_stall", 32'(o_m1_stall), 32'd1);
        step();

        // m1 drops cyc with requests outstanding; late ack is discarded
        m1_stb = 0; m1_cyc = 0;
        smp();
        chk("m1_drop_s_cyc", 32'(o_s_cyc), 32'd0);
        step();
        s_ack = 1; s_data = 32'hC0;
        smp();
        chk("late_ack_m0", 32'(o_m0_ack), 32'd0);
        chk("late_ack_m1", 32'(o_m1_ack), 32'd0);
        chk("abort_no_err", {30'd0, o_m0_err, o_m1_err}, 32'd0);
        step();
        s_ack = 0;

        // Continuous requests alternate grants
        m0_cyc = 1; m1_cyc = 1;
        step();
        smp();
        chk("alt0_m0_stall", 32'(o_m0_stall), 32'd0);
        chk("alt0_m1_stall", 32'(o_m1_stall), 32'd1);
        m0_cyc = 0;
        step();
        m0_cyc = 1;
        smp();
        chk("alt_gap_stall", {30'd0, o_m0_stall, o_m1_stall}, 32'd3);
        step();
        smp();
        chk("alt1_m1_stall", 32'(o_m1_stall), 32'd0);
        chk("alt1_m0_stall", 32'(o_m0_stall), 32'd1);
        m1_cyc = 0;
        step();
        m1_cyc = 1;
        step();
        smp();
        chk("alt2_m0_stall", 32'(o_m0_stall), 32'd0);
        chk("alt2_s_cyc", 32'(o_s_cyc), 32'd1);

        // Asynchronous reset drops the slave cycle at once
        reset = 0;
        #1;
        chk("async_rst_s_cyc", 32'(o_s_cyc), 32'd0);
        chk("async_rst_m0_stall", 32'(o_m0_stall), 32'd1);
        m0_cyc = 0; m1_cyc = 0;
        step();
        reset = 1;
        s_ack = 1; s_data = 32'hD0;
        smp();
        chk("post_rst_ack", {30'd0, o_m0_ack, o_m1_ack}, 32'd0);
        step();
        s_ack = 0;

        // Watchdog abort on the TIMEOUT=4 instance
        m0_cyc = 1;
        step();
        m0_stb = 1; m0_addr = 30'h300;
        smp();
        chk("wd_stb", 32'(t_s_stb), 32'd1);
        step();
        m0_stb = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("wd_no_err_yet", 32'(t_m0_err), 32'd0);
            chk("wd_s_cyc_held", 32'(t_s_cyc), 32'd1);
            step();
        end
        smp();
        chk("wd_err_pulse", 32'(t_m0_err), 32'd1);
        chk("wd_abort_s_cyc", 32'(t_s_cyc), 32'd0);
        chk("wd_abort_stall", 32'(t_m0_stall), 32'd1);
        chk("wd_m1_err", 32'(t_m1_err), 32'd0);
        chk("main_no_timeout", 32'(o_s_cyc), 32'd1);
        step();
        smp();
        chk("wd_err_one_cycle", 32'(t_m0_err), 32'd0);
        chk("wd_abort_held", 32'(t_s_cyc), 32'd0);
        m0_cyc = 0; m1_cyc = 1;
        step();
        smp();
        chk("wd_exit_idle_stall", 32'(t_m1_stall), 32'd1);
        step();
        smp();
        chk("wd_next_grant", 32'(t_m1_stall), 32'd0);
        chk("wd_next_s_cyc", 32'(t_s_cyc), 32'd1);

        m1_cyc = 0;
        repeat (2) step();
        chk("events_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
